// File: rtl/dmem_pipelined.sv
// Single-port data memory with a fixed-latency valid/ready request/response
// handshake, byte-enable writes and alignment/range fault detection.
module dmem_pipelined #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int unsigned BE_W     = DATA_WIDTH / 8;
  localparam int unsigned OFF_W    = $clog2(BE_W);
  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_LOAD = (LATENCY >= 2) ? LATENCY - 2 : 0;
  localparam int unsigned CNT_W    = (CNT_LOAD > 1) ? $clog2(CNT_LOAD + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    we_q;
  logic [BE_W-1:0]         be_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic                    acc_we;
  logic [BE_W-1:0]         acc_be;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic [ADDR_WIDTH-1:0]   acc_word;
  logic [IDX_W-1:0]        acc_idx;
  logic                    fault;
  logic                    enter_resp;

  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  // State and latency counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(CNT_LOAD);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture; datapath only, no reset needed
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      we_q    <= req_we;
      be_q    <= req_be;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // With LATENCY=1 the access completes on the accept edge, before capture
  always_comb begin
    acc_we     = (state_q == IDLE) ? req_we    : we_q;
    acc_be     = (state_q == IDLE) ? req_be    : be_q;
    acc_addr   = (state_q == IDLE) ? req_addr  : addr_q;
    acc_wdata  = (state_q == IDLE) ? req_wdata : wdata_q;
    acc_word   = acc_addr >> OFF_W;
    acc_idx    = acc_word[IDX_W-1:0];
    fault      = (|acc_addr[OFF_W-1:0]) | (|(acc_word >> IDX_W));
    enter_resp = (state_d == RESP) && (state_q != RESP);
  end

  // Memory commit; rst suppresses a pending write
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_we && !fault) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  // Registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      req_ready  <= (state_d == IDLE);
      resp_valid <= (state_d == RESP);
      if (enter_resp) begin
        resp_err   <= fault;
        resp_rdata <= (!fault && !acc_we) ? mem[acc_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_pipelined.sv
// Directed self-checking bench for dmem_pipelined (LATENCY 2, plus 1 and 4 builds).
module tb_dmem_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, resp_ready;
  logic [3:0]  req_be;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        v1_req_valid, v1_resp_ready, v1_req_ready, v1_resp_valid, v1_resp_err;
  logic [31:0] v1_resp_rdata;
  logic        v4_req_valid, v4_resp_ready, v4_req_ready, v4_resp_valid, v4_resp_err;
  logic [31:0] v4_resp_rdata;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dmem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err));

  dmem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .req_valid(v1_req_valid), .req_ready(v1_req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(v1_resp_valid),
    .resp_ready(v1_resp_ready), .resp_rdata(v1_resp_rdata), .resp_err(v1_resp_err));

  dmem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(4)) dut_l4 (
    .clk(clk), .rst(rst), .req_valid(v4_req_valid), .req_ready(v4_req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(v4_resp_valid),
    .resp_ready(v4_resp_ready), .resp_rdata(v4_resp_rdata), .resp_err(v4_resp_err));

  // Full transaction on the LATENCY=2 instance; lat = cycles from accept edge to resp_valid
  task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else passes++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else passes++;
    checks++; if (resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", resp_rdata); else passes++;
    checks++; if (resp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", resp_err); else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({v1_req_ready, v4_req_ready, v1_resp_valid, v4_resp_valid} !== 4'b1100)
      $display("FAIL reset_variants: got %b want 1100", {v1_req_ready, v4_req_ready, v1_resp_valid, v4_resp_valid});
    else passes++;
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++; if (lat !== 2) $display("FAIL basic_write_latency: got %0d want 2", lat); else passes++;
    checks++; if ({er, rd} !== 33'h0) $display("FAIL basic_write_resp: got err %b rdata %h want 0/0", er, rd); else passes++;
    do_req(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (lat !== 2) $display("FAIL basic_read_latency: got %0d want 2", lat); else passes++;
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL basic_read_data: got %h want deadbeef", rd); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL basic_read_err: got %b want 0", er); else passes++;
    checks++; if (req_ready !== 1'b1) $display("FAIL basic_idle_ready: got %b want 1", req_ready); else passes++;
  endtask

  task automatic test_byte_merge();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 4'hF, 32'h20, 32'h11223344, rd, er, lat);
    do_req(1'b1, 4'h5, 32'h20, 32'hAABBCCDD, rd, er, lat);
    checks++; if (er !== 1'b0) $display("FAIL merge_write_err: got %b want 0", er); else passes++;
    do_req(1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h11BB33DD) $display("FAIL merge_read_data: got %h want 11bb33dd", rd); else passes++;
  endtask

  task automatic test_be_zero();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, rd, er, lat);
    checks++; if ({er, rd} !== 33'h0) $display("FAIL be0_resp: got err %b rdata %h want 0/0", er, rd); else passes++;
    checks++; if (lat !== 2) $display("FAIL be0_latency: got %0d want 2", lat); else passes++;
    do_req(1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h11BB33DD) $display("FAIL be0_unchanged: got %h want 11bb33dd", rd); else passes++;
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 4'hF, 32'h0, 32'hCAFEF00D, rd, er, lat);
    do_req(1'b0, 4'h0, 32'h0, 32'h0, rd, er, lat);
    do_req(1'b0, 4'h0, 32'h13, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1) $display("FAIL fault_misaligned_err: got %b want 1", er); else passes++;
    checks++; if (rd !== 32'h0) $display("FAIL fault_misaligned_rdata: got %h want 0", rd); else passes++;
    do_req(1'b1, 4'hF, 32'h1000, 32'h12345678, rd, er, lat);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL fault_range_write: got err %b rdata %h want 1/0", er, rd); else passes++;
    do_req(1'b0, 4'h0, 32'h0, 32'h0, rd, er, lat);
    checks++; if ({er, rd} !== {1'b0, 32'hCAFEF00D}) $display("FAIL fault_no_alias: got err %b rdata %h want 0/cafef00d", er, rd); else passes++;
    do_req(1'b1, 4'hF, 32'hFFC, 32'h0BADC0DE, rd, er, lat);
    do_req(1'b0, 4'h0, 32'hFFC, 32'h0, rd, er, lat);
    checks++; if ({er, rd} !== {1'b0, 32'h0BADC0DE}) $display("FAIL last_word: got err %b rdata %h want 0/0badc0de", er, rd); else passes++;
  endtask

  task automatic test_backpressure();
    int lat;
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'h0; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    // A hostile write is presented while the response is stalled
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({resp_valid, req_ready, resp_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF})
        $display("FAIL stall_hold_%0d: got valid %b ready %b rdata %h want 1/0/deadbeef", i, resp_valid, req_ready, resp_rdata);
      else passes++;
      @(posedge clk); #1;
    end
    resp_ready = 1'b1; req_we = 1'b0;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL consume_edge: got valid %b ready %b want 0/1", resp_valid, req_ready); else passes++;
    checks++; if (resp_rdata !== 32'hDEADBEEF) $display("FAIL idle_rdata_hold: got %h want deadbeef", resp_rdata); else passes++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) $display("FAIL accept_after_consume: got ready %b want 0", req_ready); else passes++;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 2) $display("FAIL stall_next_latency: got %0d want 2", lat); else passes++;
    checks++; if (resp_rdata !== 32'hDEADBEEF) $display("FAIL stall_ignored_write: got %h want deadbeef", resp_rdata); else passes++;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 4'hF, 32'h40, 32'h0, rd, er, lat);
    do_req(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 32'h40; req_wdata = 32'h55555555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if ({req_ready, resp_valid, resp_rdata} !== {2'b00, 32'hDEADBEEF})
      $display("FAIL wait_state: got ready %b valid %b rdata %h want 0/0/deadbeef", req_ready, resp_valid, resp_rdata);
    else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL midop_reset_hs: got valid %b ready %b want 0/1", resp_valid, req_ready); else passes++;
    checks++; if (resp_rdata !== 32'h0) $display("FAIL midop_reset_rdata: got %h want 0", resp_rdata); else passes++;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) $display("FAIL midop_no_resp: got %b want 0", resp_valid); else passes++;
    do_req(1'b0, 4'h0, 32'h40, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0) $display("FAIL midop_discarded: got %h want 0", rd); else passes++;
  endtask

  task automatic test_latency_variants();
    int lat1, lat4;
    lat1 = 0; lat4 = 0;
    req_we = 1'b0; req_be = 4'h0; req_addr = 32'h8;
    v1_req_valid = 1'b1; v4_req_valid = 1'b1;
    @(posedge clk); #1;
    v1_req_valid = 1'b0; v4_req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (v1_resp_valid && lat1 == 0) lat1 = c;
      if (v4_resp_valid && lat4 == 0) lat4 = c;
      @(posedge clk); #1;
    end
    checks++; if (lat1 !== 1) $display("FAIL latency1: got %0d want 1", lat1); else passes++;
    checks++; if (lat4 !== 4) $display("FAIL latency4: got %0d want 4", lat4); else passes++;
    checks++; if ({v1_resp_valid, v4_resp_valid, v1_req_ready, v4_req_ready} !== 4'b1100)
      $display("FAIL variants_held: got %b want 1100", {v1_resp_valid, v4_resp_valid, v1_req_ready, v4_req_ready});
    else passes++;
    v1_resp_ready = 1'b1; v4_resp_ready = 1'b1;
    @(posedge clk); #1;
    v1_resp_ready = 1'b0; v4_resp_ready = 1'b0;
    checks++; if ({v1_resp_valid, v4_resp_valid, v1_req_ready, v4_req_ready} !== 4'b0011)
      $display("FAIL variants_release: got %b want 0011", {v1_resp_valid, v4_resp_valid, v1_req_ready, v4_req_ready});
    else passes++;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_addr = 32'h0;
    req_wdata = 32'h0; resp_ready = 1'b0;
    v1_req_valid = 1'b0; v1_resp_ready = 1'b0; v4_req_valid = 1'b0; v4_resp_ready = 1'b0;
    test_reset();
    test_basic();
    test_byte_merge();
    test_be_zero();
    test_faults();
    test_backpressure();
    test_reset_mid_op();
    test_latency_variants();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
